// File: rtl/kgp_branch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kgp_branch_pkg
// Description : Shared definitions for the KGP-RISC branch sequencer: FSM
//               state encoding, branch class codes, per-class condition
//               codes, flag bundle and the default reset PC.
// Revision    : 1.0 - initial release
// ============================================================================
package kgp_branch_pkg;

  // Sequencer states, explicit 3-bit encoding
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_UPDATE = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  // Decoded branch class
  localparam logic [1:0] C_CLS_NONE   = 2'b00;
  localparam logic [1:0] C_CLS_COND   = 2'b01;
  localparam logic [1:0] C_CLS_UNCOND = 2'b10;
  localparam logic [1:0] C_CLS_REG    = 2'b11;

  // Conditional-class selectors (tested against stored Z / N)
  localparam logic [1:0] C_COND_NEVER = 2'b00;
  localparam logic [1:0] C_COND_BNZ   = 2'b01;
  localparam logic [1:0] C_COND_BLTZ  = 2'b10;
  localparam logic [1:0] C_COND_BZ    = 2'b11;

  // Unconditional-class selectors (tested against stored C)
  localparam logic [1:0] C_UNC_B      = 2'b00;
  localparam logic [1:0] C_UNC_BLB    = 2'b01;
  localparam logic [1:0] C_UNC_BNCY   = 2'b10;
  localparam logic [1:0] C_UNC_BCY    = 2'b11;

  localparam logic [31:0] C_DEFAULT_RESET_PC = 32'h0000_0000;

  // Flags captured from the last flag-writing ALU operation
  typedef struct packed {
    logic zero;
    logic carry;
    logic negative;
  } flags_t;

endpackage
`default_nettype wire

// File: rtl/branch_resolve.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve
// Description : Combinational branch resolution: evaluates the condition
//               against stored flags, forms the target and selects next PC.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve
  import kgp_branch_pkg::*;
(
  input  logic [1:0]  br_cls,
  input  logic [1:0]  br_ctl,
  input  flags_t      flags,
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  input  logic [25:0] pseudo_add,
  input  logic [31:0] reg_target,
  output logic        taken,
  output logic [31:0] next_pc,
  output logic        link
);

  logic [31:0] w_seq_pc;
  logic [31:0] w_cond_tgt;
  logic [31:0] w_unc_tgt;
  logic [31:0] w_reg_tgt;

  // Offsets are in words; all additions wrap modulo 2^32
  assign w_seq_pc   = pc + 32'd4;
  assign w_cond_tgt = w_seq_pc + (imm << 2);
  assign w_unc_tgt  = {pc[31:28], pseudo_add, 2'b00};
  assign w_reg_tgt  = reg_target & ~32'h0000_0003;

  // Condition evaluation and final PC select
  always_comb begin
    taken   = 1'b0;
    link    = 1'b0;
    next_pc = w_seq_pc;
    case (br_cls)
      C_CLS_COND: begin
        case (br_ctl)
          C_COND_BZ:   taken = flags.zero;
          C_COND_BNZ:  taken = ~flags.zero;
          C_COND_BLTZ: taken = flags.negative;
          default:     taken = 1'b0;
        endcase
        if (taken) next_pc = w_cond_tgt;
      end
      C_CLS_UNCOND: begin
        case (br_ctl)
          C_UNC_BCY:  taken = flags.carry;
          C_UNC_BNCY: taken = ~flags.carry;
          C_UNC_BLB: begin
            taken = 1'b1;
            link  = 1'b1;
          end
          default:    taken = 1'b1;
        endcase
        if (taken) next_pc = w_unc_tgt;
      end
      C_CLS_REG: begin
        taken   = 1'b1;
        next_pc = w_reg_tgt;
      end
      default: begin
        taken   = 1'b0;
        next_pc = w_seq_pc;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/branch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : branch_sequencer
// Description : Handshaked fetch/decode/execute/update PC sequencer for the
//               KGP-RISC core. Owns PC, instruction latch and flag register.
//               Optional macro BRANCH_STATS_EN adds saturating branch and
//               taken-branch counters as outputs br_count / taken_count.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_sequencer
  import kgp_branch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = C_DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [31:0] instr,
  input  logic [1:0]  br_cls,
  input  logic [1:0]  br_ctl,
  input  logic        halt_dec,
  input  logic [31:0] imm,
  input  logic [25:0] pseudo_add,
  input  logic [31:0] reg_target,
  output logic        alu_go,
  input  logic        alu_done,
  input  logic        flag_we,
  input  logic        zero,
  input  logic        carry,
  input  logic        negative,
  output logic        link_we,
  output logic [31:0] link_addr,
  output logic [31:0] pc,
  output logic        busy,
  output logic        halted
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0] br_count,
  output logic [31:0] taken_count
`endif
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  flags_t      r_flags;
  logic        w_taken;
  logic        w_link;
  logic [31:0] w_next_pc;

  branch_resolve u_resolve (
    .br_cls     (br_cls),
    .br_ctl     (br_ctl),
    .flags      (r_flags),
    .pc         (r_pc),
    .imm        (imm),
    .pseudo_add (pseudo_add),
    .reg_target (reg_target),
    .taken      (w_taken),
    .next_pc    (w_next_pc),
    .link       (w_link)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and handshake outputs; outputs decode from state only so an
  // asynchronous reset drops requests immediately
  always_comb begin
    w_state_nxt = r_state;
    imem_req    = 1'b0;
    alu_go      = 1'b0;
    link_we     = 1'b0;
    case (r_state)
      ST_IDLE:   if (start) w_state_nxt = ST_FETCH;
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) w_state_nxt = ST_DECODE;
      end
      ST_DECODE: begin
        if (halt_dec)                  w_state_nxt = ST_HALT;
        else if (br_cls == C_CLS_NONE) w_state_nxt = ST_EXEC;
        else                           w_state_nxt = ST_UPDATE;
      end
      ST_EXEC: begin
        alu_go = 1'b1;
        if (alu_done) w_state_nxt = ST_UPDATE;
      end
      ST_UPDATE: begin
        link_we     = w_link & w_taken;
        w_state_nxt = ST_FETCH;
      end
      ST_HALT:   w_state_nxt = ST_HALT;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // PC only moves on the UPDATE edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_pc <= RESET_PC;
    else if (r_state == ST_UPDATE) r_pc <= w_next_pc;
  end

  // Instruction latch, loaded on fetch completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                r_instr <= 32'h0;
    else if ((r_state == ST_FETCH) && imem_ack) r_instr <= imem_data;
  end

  // Flag register, written only by flag-writing ALU operations
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                         r_flags <= '0;
    else if ((r_state == ST_EXEC) && alu_done && flag_we) r_flags <= {zero, carry, negative};
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] r_br_count;
  logic [31:0] r_taken_count;

  // Saturating statistics for branches resolved in UPDATE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_br_count    <= 32'h0;
      r_taken_count <= 32'h0;
    end else if ((r_state == ST_UPDATE) && (br_cls != C_CLS_NONE)) begin
      if (r_br_count != 32'hFFFF_FFFF) r_br_count <= r_br_count + 32'd1;
      if (w_taken && (r_taken_count != 32'hFFFF_FFFF)) r_taken_count <= r_taken_count + 32'd1;
    end
  end

  assign br_count    = r_br_count;
  assign taken_count = r_taken_count;
`endif

  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign instr     = r_instr;
  assign link_addr = r_pc + 32'd4;
  assign busy      = (r_state != ST_IDLE) && (r_state != ST_HALT);
  assign halted    = (r_state == ST_HALT);

endmodule
`default_nettype wire

// File: tb/tb_branch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_sequencer
// Description : Self-checking bench for branch_sequencer: directed vector
//               table, hand-written reset/halt sequences and random
//               instructions scored against a behavioural PC model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, start, imem_req, imem_ack, halt_dec, alu_go, alu_done;
  logic        flag_we, zero, carry, negative, link_we, busy, halted;
  logic [31:0] imem_addr, imem_data, instr, imm, reg_target, link_addr, pc;
  logic [1:0]  br_cls, br_ctl;
  logic [25:0] pseudo_add;
`ifdef BRANCH_STATS_EN
  logic [31:0] br_count, taken_count;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] m_pc;
  logic [2:0]  m_flags;   // {Z,C,N}

  typedef struct {
    logic [1:0]  cls;
    logic [1:0]  ctl;
    logic        halt;
    logic [31:0] imm;
    logic [25:0] pa;
    logic [31:0] rt;
    logic        fwe;
    logic [2:0]  zcn;
    int          ack_dly;
    int          done_dly;
    logic [31:0] word;
  } ins_t;

  typedef struct {
    logic [2:0]  zcn;
    logic [31:0] spc;
    ins_t        ins;
    logic [31:0] epc;
    logic        elink;
  } vec_t;

  vec_t tv[12];

  branch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .instr(instr), .br_cls(br_cls), .br_ctl(br_ctl), .halt_dec(halt_dec),
    .imm(imm), .pseudo_add(pseudo_add), .reg_target(reg_target),
    .alu_go(alu_go), .alu_done(alu_done), .flag_we(flag_we), .zero(zero),
    .carry(carry), .negative(negative), .link_we(link_we),
    .link_addr(link_addr), .pc(pc), .busy(busy), .halted(halted)
`ifdef BRANCH_STATS_EN
    , .br_count(br_count), .taken_count(taken_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic ins_t mk(input logic [1:0] cls, input logic [1:0] ctl,
                              input logic [31:0] im, input logic [25:0] pa,
                              input logic [31:0] rt);
    ins_t d;
    d.cls = cls; d.ctl = ctl; d.halt = 1'b0; d.imm = im; d.pa = pa; d.rt = rt;
    d.fwe = 1'b0; d.zcn = 3'b000; d.ack_dly = 0; d.done_dly = 0; d.word = $urandom;
    return d;
  endfunction

  // Branch rules evaluated directly from the instruction set description
  function automatic logic [31:0] model_next(input logic [31:0] p, input ins_t d,
                                             input logic [2:0] f, output logic lk);
    bit z, c, n, tk;
    logic [31:0] seq;
    z = f[2]; c = f[1]; n = f[0];
    seq = p + 32'd4;
    lk = 1'b0;
    tk = 1'b0;
    if (d.cls == 2'd1) begin
      tk = (d.ctl == 2'd3 && z) || (d.ctl == 2'd1 && !z) || (d.ctl == 2'd2 && n);
      return tk ? seq + d.imm * 4 : seq;
    end else if (d.cls == 2'd2) begin
      tk = (d.ctl == 2'd3 && c) || (d.ctl == 2'd2 && !c) || (d.ctl < 2'd2);
      lk = (d.ctl == 2'd1);
      return tk ? (p & 32'hF000_0000) + d.pa * 4 : seq;
    end else if (d.cls == 2'd3) begin
      return d.rt - (d.rt % 4);
    end
    return seq;
  endfunction

  // Runs one instruction through fetch/decode/exec/update; entered and left on a negedge
  task automatic do_instr(input ins_t d, input logic [31:0] exp_pc, input logic exp_link);
    int n;
    logic [31:0] a0;
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("fetch_req", {31'b0, imem_req}, 32'd1);
    chk("fetch_addr", imem_addr, m_pc);
    a0 = imem_addr;
    for (int i = 0; i < d.ack_dly; i++) begin
      @(negedge clk);
      chk("fetch_req_hold", {31'b0, imem_req}, 32'd1);
      chk("fetch_addr_hold", imem_addr, a0);
    end
    imem_ack = 1'b1; imem_data = d.word;
    br_cls = d.cls; br_ctl = d.ctl; halt_dec = d.halt;
    imm = d.imm; pseudo_add = d.pa; reg_target = d.rt;
    @(negedge clk);
    imem_ack = 1'b0; imem_data = $urandom;
    chk("instr_latch", instr, d.word);
    chk("req_drop", {31'b0, imem_req}, 32'd0);
    chk("pc_decode", pc, m_pc);
    if (d.halt) begin
      @(negedge clk);
      chk("halted", {31'b0, halted}, 32'd1);
      chk("halt_busy", {31'b0, busy}, 32'd0);
      return;
    end
    if (d.cls == 2'd0) begin
      chk("go_decode", {31'b0, alu_go}, 32'd0);
      @(negedge clk);
      for (int i = 0; i < d.done_dly; i++) begin
        chk("go_hold", {31'b0, alu_go}, 32'd1);
        @(negedge clk);
      end
      chk("go", {31'b0, alu_go}, 32'd1);
      alu_done = 1'b1; flag_we = d.fwe; {zero, carry, negative} = d.zcn;
      @(negedge clk);
      alu_done = 1'b0; flag_we = 1'b0;
      if (d.fwe) m_flags = d.zcn;
      {zero, carry, negative} = ~m_flags;
    end else begin
      // stray completion while decoding a branch must be ignored
      alu_done = 1'b1; flag_we = 1'b1;
      @(negedge clk);
      alu_done = 1'b0; flag_we = 1'b0;
    end
    chk("pc_hold_update", pc, m_pc);
    chk("go_update", {31'b0, alu_go}, 32'd0);
    chk("link_we", {31'b0, link_we}, {31'b0, exp_link});
    chk("link_addr", link_addr, m_pc + 32'd4);
    @(negedge clk);
    chk("next_pc", pc, exp_pc);
    chk("link_we_pulse", {31'b0, link_we}, 32'd0);
    m_pc = exp_pc;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_pc"}, pc, 32'h0);
    chk({tag, "_ctl"}, {26'b0, imem_req, alu_go, link_we, busy, halted, 1'b0}, 32'd0);
    chk({tag, "_instr"}, instr, 32'h0);
  endtask

  task automatic kick();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    ins_t d;
    logic lk;
    logic [31:0] e;

    rst_n = 1'b0; start = 1'b0; imem_ack = 1'b0; imem_data = 32'h0;
    br_cls = 2'b0; br_ctl = 2'b0; halt_dec = 1'b0; imm = 32'h0;
    pseudo_add = 26'h0; reg_target = 32'h0; alu_done = 1'b0; flag_we = 1'b0;
    {zero, carry, negative} = 3'b111;
    m_pc = 32'h0; m_flags = 3'b000;

    // ---------------- reset and startup timing ----------------
    #12;
    reset_checks("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    kick();
    chk("start_fetch", {31'b0, imem_req}, 32'd1);
    chk("start_addr", imem_addr, 32'h0);
    imem_ack = 1'b1; imem_data = 32'h1234_5678; br_cls = 2'b00;
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    chk("start_exec", {31'b0, alu_go}, 32'd1);
    @(negedge clk);
    alu_done = 1'b1; flag_we = 1'b0;
    @(negedge clk);
    alu_done = 1'b0;
    chk("start_pc_before", pc, 32'h0);
    @(negedge clk);
    chk("start_pc_5cyc", pc, 32'h4);
    m_pc = 32'h4;
    d = mk(2'b00, 2'b00, 0, 0, 0); do_instr(d, 32'h8, 1'b0);
    d = mk(2'b00, 2'b00, 0, 0, 0); d.ack_dly = 2; d.done_dly = 1; do_instr(d, 32'hC, 1'b0);

    // ---------------- directed vector table ----------------
    tv[0]  = '{3'b100, 32'h0000_0100, mk(2'b01, 2'b11, 32'hFFFF_FFFE, 0, 0), 32'h0000_00FC, 1'b0};
    tv[1]  = '{3'b000, 32'h0000_0100, mk(2'b01, 2'b11, 32'hFFFF_FFFE, 0, 0), 32'h0000_0104, 1'b0};
    tv[2]  = '{3'b000, 32'h0000_0200, mk(2'b01, 2'b01, 32'h3, 0, 0),        32'h0000_0210, 1'b0};
    tv[3]  = '{3'b001, 32'hFFFF_FFFC, mk(2'b01, 2'b10, 32'h1, 0, 0),        32'h0000_0004, 1'b0};
    tv[4]  = '{3'b111, 32'h0000_0300, mk(2'b01, 2'b00, 32'h5, 0, 0),        32'h0000_0304, 1'b0};
    tv[5]  = '{3'b010, 32'h1000_0000, mk(2'b10, 2'b11, 0, 26'h3, 0),        32'h1000_000C, 1'b0};
    tv[6]  = '{3'b010, 32'h0000_0400, mk(2'b10, 2'b10, 0, 26'h3, 0),        32'h0000_0404, 1'b0};
    tv[7]  = '{3'b000, 32'h5000_0000, mk(2'b10, 2'b10, 0, 26'h3FF_FFFF, 0), 32'h5FFF_FFFC, 1'b0};
    tv[8]  = '{3'b000, 32'hA000_0010, mk(2'b10, 2'b01, 0, 26'h40, 0),       32'hA000_0100, 1'b1};
    tv[9]  = '{3'b010, 32'h7000_0020, mk(2'b10, 2'b00, 0, 26'h10, 0),       32'h7000_0040, 1'b0};
    tv[10] = '{3'b000, 32'h0000_0800, mk(2'b11, 2'b01, 0, 0, 32'h1237),     32'h0000_1234, 1'b0};
    tv[11] = '{3'b000, 32'hFFFF_FFFC, mk(2'b00, 2'b00, 0, 0, 0),            32'h0000_0000, 1'b0};
    for (int i = 0; i < 12; i++) begin
      d = mk(2'b00, 2'b00, 0, 0, 0); d.fwe = 1'b1; d.zcn = tv[i].zcn;
      do_instr(d, m_pc + 32'd4, 1'b0);
      d = mk(2'b11, 2'b00, 0, 0, tv[i].spc);
      do_instr(d, tv[i].spc, 1'b0);
      do_instr(tv[i].ins, tv[i].epc, tv[i].elink);
    end

    // ---------------- flag_we=0 keeps stored flags ----------------
    d = mk(2'b00, 2'b00, 0, 0, 0); d.fwe = 1'b1; d.zcn = 3'b100;
    do_instr(d, m_pc + 32'd4, 1'b0);
    d = mk(2'b00, 2'b00, 0, 0, 0); d.fwe = 1'b0; d.zcn = 3'b000;
    do_instr(d, m_pc + 32'd4, 1'b0);
    d = mk(2'b01, 2'b01, 32'h10, 0, 0);
    do_instr(d, m_pc + 32'd4, 1'b0);

    // ---------------- random instructions vs model ----------------
    start = 1'b1;   // start while busy has no effect
    for (int i = 0; i < 60; i++) begin
      d = mk(2'($urandom), 2'($urandom), $urandom, 26'($urandom), $urandom);
      if ($urandom_range(0, 3) == 0) d.imm = 32'($signed($urandom_range(0, 16)) - 8);
      d.fwe = 1'($urandom); d.zcn = 3'($urandom);
      d.ack_dly = $urandom_range(0, 2); d.done_dly = $urandom_range(0, 2);
      e = model_next(m_pc, d, m_flags, lk);
      do_instr(d, e, lk);
    end
    start = 1'b0;

    // ---------------- async reset mid-EXEC ----------------
    d = mk(2'b11, 2'b00, 0, 0, 32'h0000_1230); do_instr(d, 32'h0000_1230, 1'b0);
    d = mk(2'b00, 2'b00, 0, 0, 0); d.fwe = 1'b1; d.zcn = 3'b111;
    do_instr(d, m_pc + 32'd4, 1'b0);
    imem_ack = 1'b1; br_cls = 2'b00; halt_dec = 1'b0;
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    chk("exec_go_before_rst", {31'b0, alu_go}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    reset_checks("rst_exec");
    @(negedge clk);
    rst_n = 1'b1; m_pc = 32'h0; m_flags = 3'b000;
    @(negedge clk);
    chk("idle_no_req", {31'b0, imem_req}, 32'd0);

    // ---------------- async reset mid-FETCH ----------------
    kick();
    chk("fetch_before_rst", {31'b0, imem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    reset_checks("rst_fetch");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    kick();
    // flags cleared by reset: bnz taken, bz not
    d = mk(2'b01, 2'b01, 32'h4, 0, 0); do_instr(d, 32'h14, 1'b0);
    d = mk(2'b01, 2'b11, 32'h4, 0, 0); do_instr(d, 32'h18, 1'b0);

    // ---------------- halt is terminal ----------------
    d = mk(2'b00, 2'b00, 0, 0, 0); d.halt = 1'b1;
    do_instr(d, 32'h0, 1'b0);
    halt_dec = 1'b0;
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    chk("halt_stays", {31'b0, halted}, 32'd1);
    chk("halt_no_req", {31'b0, imem_req}, 32'd0);
    chk("halt_pc", pc, m_pc);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time bound so the run always terminates
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/branch_sequencer.md
# branch_sequencer

Multi-cycle program-counter sequencer for the KGP-RISC core: owns the PC register, drives instruction fetch, hands non-branch instructions to the ALU and resolves branches against stored flags. It sits between instruction memory, the decoder and the ALU and replaces the free-running PC update with a handshaked fetch/decode/execute/update loop. Branch resolution (condition evaluation, target formation, final PC select) is internal.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  leave IDLE and begin fetching at current PC
- imem_req  out  1  fetch request, held until imem_ack
- imem_addr  out  32  fetch address (equals pc)
- imem_ack  in  1  fetch complete; imem_data valid this cycle
- imem_data  in  32  fetched word
- instr  out  32  latched instruction, stable from DECODE until next FETCH
- br_cls  in  2  decoded class: 00 none, 01 conditional, 10 unconditional, 11 register
- br_ctl  in  2  condition selector (see Operation)
- halt_dec  in  1  decoded halt
- imm  in  32  sign-extended conditional offset (words)
- pseudo_add  in  26  unconditional pseudo-address (words)
- reg_target  in  32  register-branch target
- alu_go  out  1  ALU execute request, held until alu_done
- alu_done  in  1  ALU finished; flags valid this cycle
- flag_we  in  1  instruction updates flags (sampled with alu_done)
- zero, carry, negative  in  1  ALU flags
- link_we  out  1  one-cycle link write strobe; link_addr  out  32  = pc+4
- pc  out  32  current PC
- busy  out  1  state != IDLE and != HALT
- halted  out  1  state == HALT

## Operation
- States: IDLE, FETCH, DECODE, EXEC, UPDATE, HALT.
- IDLE -> FETCH on start. FETCH: imem_req=1; on imem_ack latch instr, -> DECODE.
- DECODE (1 cycle): halt_dec -> HALT; br_cls==00 -> EXEC; else -> UPDATE.
- EXEC: alu_go=1 until alu_done; on alu_done, if flag_we capture {zero,carry,negative} into flag register; -> UPDATE.
- UPDATE (1 cycle): pc <= next_pc; -> FETCH.
- Branches use the flag register (flags of last flag-writing instruction), never live flag inputs.
- Conditional (01): 11 bz (Z), 01 bnz (!Z), 10 bltz (N), 00 never. Target = pc+4 + (imm<<2), mod 2^32.
- Unconditional (10): 11 bcy (C), 10 bncy (!C), 01 blb (always, link_we=1 in UPDATE), 00 b (always). Target = {pc[31:28], pseudo_add, 2'b00}.
- Register (11): always taken, target = reg_target[31:2],2'b00.
- Not taken or class 00: next_pc = pc+4, wraps FFFF_FFFC -> 0000_0000.
- HALT is terminal; only rst_n exits.

## Timing
- Reset (async): state IDLE, pc=RESET_PC, flags=0, instr=0; imem_req, alu_go, link_we, busy, halted all 0 immediately.
- Minimum loop: FETCH(1, same-cycle ack)+DECODE+UPDATE = 3 cycles for branches; +EXEC (≥1) for others.
- imem_ack/alu_done ignored outside FETCH/EXEC. Request never drops before ack/done.
- imem_addr stable for whole FETCH. pc changes only on UPDATE clock edge.
- rst_n asserted mid-FETCH/EXEC: request drops asynchronously, transaction abandoned, no PC or flag update.
- start while busy: ignored.

## Configuration
- BRANCH_STATS_EN defined: adds outputs br_count[31:0] (branches resolved in UPDATE) and taken_count[31:0] (taken subset), reset to 0, saturating at FFFF_FFFF. Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- Shared package kgp_branch_pkg: state encoding, br_cls codes, per-class br_ctl codes, RESET_PC default.
- One sub-module: branch_resolve (combinational: class/ctl/flags/pc/imm/pseudo_add/reg_target -> taken, next_pc, link). FSM and registers stay in branch_sequencer.

## Test plan
- Reset/startup: rst_n low then high, start pulse, imem_ack same cycle, class 00, alu_done after 2 cycles -> fetches at 0,4,8; pc=4 after 5 cycles from start.
- bz taken: prior ALU op sets Z=1 with flag_we=1; at pc=0x100, br_cls=01, br_ctl=11, imm=-2 -> pc=0x0FC.
- flag_we=0 preserves flags: Z set, then non-flag op outputs zero=0, then bnz -> not taken, pc=+4.
- blb at pc=0xA000_0010, pseudo_add=0x40 -> pc=0xA000_0100, link_we one cycle, link_addr=0xA000_0014.
- Wrap: pc=0xFFFF_FFFC class 00 -> pc=0; bltz with N=1, imm=1 at same pc -> pc=0x0000_0004.
- Async reset mid-EXEC (alu_go high) -> alu_go low same cycle, pc=RESET_PC; halt_dec -> halted=1, further start ignored.
